voltage_text_scheduler: RTL and testbench
=========================================

# voltage_text_scheduler

Sequences the shared BCD-to-ASCII conversion path for the 13-channel voltmeter display. On a start pulse it walks every channel, fetches that channel's 4-digit BCD reading, and converts each digit through a single registered converter instance. It writes a formatted 6-character line per channel ("d.dddV") into the character buffer read by the VGA text renderer. The block sits between the per-channel BCD result store and the character RAM.

## Interface
- N_CH, 13, number of channels scanned per frame
- LINE_STRIDE, 8, character-address stride between channel lines (power of two)
- ADDR_W, 7, character-buffer address width; N_CH*LINE_STRIDE must be ≤ 2^ADDR_W
- clk  in  1  system clock
- rst  in  1  reset: one clock, synchronous, active-high
- start  in  1  one-cycle request to rebuild all lines; ignored while busy
- ch_addr  out  4  channel index presented to the BCD store
- bcd_data  in  16  BCD reading for ch_addr, valid the cycle after ch_addr changes; [15:12]=volts, [11:8]/[7:4]/[3:0]=tenths/hundredths/thousandths
- wr_en  out  1  character-buffer write strobe
- wr_addr  out  ADDR_W  character address = ch*LINE_STRIDE + pos
- wr_data  out  7  ASCII character
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse after the last write of a scan
- bcd_err  out  1  sticky flag: a digit >9 was seen this scan

## Operation
- Reset: all outputs 0 (ch_addr=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, bcd_err=0); FSM to IDLE.
- FSM states: IDLE, FETCH, EMIT, FLUSH.
- IDLE: on start go to FETCH with ch=0 and pos=0; clear bcd_err; set busy.
- FETCH (1 cycle): ch_addr=ch; capture bcd_data into a local latch at the end of the cycle; go to EMIT.
- EMIT (6 cycles, pos 0..5). Character per pos:
  - pos 0: d3 via converter
  - pos 1: '.' (0x2E)
  - pos 2: d2 via converter
  - pos 3: d1 via converter
  - pos 4: d0 via converter
  - pos 5: 'V' (0x56)
- Constants bypass the converter but pass through a matching 1-cycle delay register, so every write occurs exactly one cycle after its EMIT cycle.
- At pos 5: if ch==N_CH-1 go to FLUSH, else ch+1 and go to FETCH.
- FLUSH (1 cycle): the last write is issued; then go to IDLE with busy=0 and done pulsed.
- Converter maps 0..9 to 0x30..0x39 and any other value to 0x7F. A converted digit >9 sets bcd_err, which stays set until the next start.
- Line positions 6..LINE_STRIDE-1 are never written.
- start while busy: no effect. start together with rst: rst wins.
- rst mid-scan: wr_en low from the next cycle, no further writes, no done pulse.

## Timing
- start sampled high in cycle 0. Channel k: FETCH in cycle 1+7k, EMIT in cycles 2+7k..7+7k, writes in cycles 3+7k..8+7k.
- With N_CH=13: last write in cycle 92, busy high in cycles 1..92, done high in cycle 93 with busy low.
- A new start is accepted in cycle 93.
- wr_en, wr_addr and wr_data are registered and change together. There is no backpressure: the buffer accepts every write.
- ch_addr holds its last value in IDLE.

## Structure
- Shared package holds:
  - ASCII constants: ASCII_ZERO=0x30, ASCII_DOT=0x2E, ASCII_V=0x56, ASCII_INVALID=0x7F
  - CHARS_PER_LINE=6
  - state encoding
- One sub-module: bcd2ascii1_4, the team's existing registered 4-bit BCD-to-7-bit-ASCII converter, instantiated once. Its 1-cycle latency sets the write-pipeline alignment.
- FSM, channel/position counters, constant-delay register and write-output registers live in this module.

## Test plan
- Reset, then start with every channel returning 0x1234. Required:
  - 78 writes, 6 per channel.
  - Channel 0 writes "1.234V" to addresses 0..5, first write in cycle 3.
  - Channel 12 writes to addresses 96..101.
  - done in cycle 93; bcd_err=0.
- Channel 5 returns 0x9A05, all others valid. Required: address 40 gets '9', address 42 gets 0x7F, bcd_err=1 after the scan. A following start clears bcd_err.
- start pulsed again in cycle 40. Required: ignored, write sequence and done timing unchanged.
- rst asserted in cycle 20. Required: wr_en=0 from cycle 21, no done, all outputs at reset values. A start afterwards performs a full clean scan.
- start and rst high in the same cycle. Required: stays IDLE, busy=0.
- Back-to-back scans: start in cycle 93. Required: first FETCH in cycle 94 with ch_addr=0, identical write pattern.

Source files
------------

// File: rtl/voltage_text_scheduler_pkg.sv
// rtl/voltage_text_scheduler_pkg.sv - shared constants and state encoding for the voltmeter text scheduler
package voltage_text_scheduler_pkg;

  localparam logic [6:0] ASCII_ZERO    = 7'h30;
  localparam logic [6:0] ASCII_DOT     = 7'h2E;
  localparam logic [6:0] ASCII_V       = 7'h56;
  localparam logic [6:0] ASCII_INVALID = 7'h7F;

  localparam int CHARS_PER_LINE = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  // Line positions that carry a BCD digit rather than a fixed character.
  function automatic logic pos_is_digit(input logic [2:0] pos);
    return (pos == 3'd0) || (pos == 3'd2) || (pos == 3'd3) || (pos == 3'd4);
  endfunction

endpackage

// File: rtl/bcd2ascii1_4.sv
// rtl/bcd2ascii1_4.sv - registered 4-bit BCD to 7-bit ASCII digit converter, one cycle latency
module bcd2ascii1_4
  import voltage_text_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd,
  output logic [6:0] ascii
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ascii <= 7'd0;
    end else if (bcd <= 4'd9) begin
      ascii <= ASCII_ZERO + {3'b000, bcd};
    end else begin
      ascii <= ASCII_INVALID;
    end
  end

endmodule

// File: rtl/voltage_text_scheduler.sv
// rtl/voltage_text_scheduler.sv - walks all channels and writes "d.dddV" lines into the character buffer
module voltage_text_scheduler
  import voltage_text_scheduler_pkg::*;
#(
  parameter int N_CH        = 13,
  parameter int LINE_STRIDE = 8,
  parameter int ADDR_W      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [3:0]        ch_addr,
  input  logic [15:0]       bcd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [6:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              bcd_err
);

  logic [1:0]  state;
  logic [3:0]  ch;
  logic [2:0]  pos;
  logic [15:0] bcd_q;
  logic [3:0]  digit;
  logic        use_conv;
  logic [6:0]  const_char;
  logic        emitting;
  logic [6:0]  const_q;
  logic        use_conv_q;
  logic [6:0]  conv_ascii;

  assign ch_addr  = ch;
  assign emitting = (state == ST_EMIT);

  always_comb begin
    digit      = 4'd0;
    use_conv   = pos_is_digit(pos);
    const_char = (pos == 3'd1) ? ASCII_DOT : ASCII_V;
    case (pos)
      3'd0:    digit = bcd_q[15:12];
      3'd2:    digit = bcd_q[11:8];
      3'd3:    digit = bcd_q[7:4];
      3'd4:    digit = bcd_q[3:0];
      default: digit = 4'd0;
    endcase
  end

  bcd2ascii1_4 u_conv (
    .clk   (clk),
    .rst   (rst),
    .bcd   (digit),
    .ascii (conv_ascii)
  );

  // Constants are delayed one cycle so they line up with the converter output.
  assign wr_data = use_conv_q ? conv_ascii : const_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ch         <= 4'd0;
      pos        <= 3'd0;
      bcd_q      <= 16'd0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      const_q    <= 7'd0;
      use_conv_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      done  <= 1'b0;
      wr_en <= emitting;
      if (emitting) begin
        wr_addr    <= ADDR_W'(ch) * ADDR_W'(LINE_STRIDE) + ADDR_W'(pos);
        const_q    <= const_char;
        use_conv_q <= use_conv;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_FETCH;
            ch      <= 4'd0;
            pos     <= 3'd0;
            busy    <= 1'b1;
            bcd_err <= 1'b0;
          end
        end
        ST_FETCH: begin
          bcd_q <= bcd_data;
          state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (use_conv && (digit > 4'd9)) begin
            bcd_err <= 1'b1;
          end
          if (pos == 3'(CHARS_PER_LINE - 1)) begin
            pos <= 3'd0;
            if (ch == 4'(N_CH - 1)) begin
              state <= ST_FLUSH;
            end else begin
              ch    <= ch + 4'd1;
              state <= ST_FETCH;
            end
          end else begin
            pos <= pos + 3'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voltage_text_scheduler.sv
// tb/tb_voltage_text_scheduler.sv - table-driven bench for voltage_text_scheduler
module tb_voltage_text_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  ch_addr;
  logic [15:0] bcd_data;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [6:0]  wr_data;
  logic        busy;
  logic        done;
  logic        bcd_err;

  logic [15:0] bcd0;
  logic [15:0] bcd5;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] bcd5;
    logic [6:0]  d3, d2, d1, d0;
    logic        err;
    int          restart;
    bit          b2b;
  } vec_t;

  vec_t vecs [6];
  logic [6:0] base_line [6];

  always #5 clk = ~clk;

  assign bcd_data = (ch_addr == 4'd5) ? bcd5 : ((ch_addr == 4'd0) ? bcd0 : 16'h1234);

  voltage_text_scheduler #(.N_CH(13), .LINE_STRIDE(8), .ADDR_W(7)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ch_addr  (ch_addr),
    .bcd_data (bcd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .bcd_err  (bcd_err)
  );

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got %0h want %0h", name, c, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input int c);
    chk({tag, " ch_addr"}, c, 32'(ch_addr), 32'd0);
    chk({tag, " wr_en"},   c, 32'(wr_en),   32'd0);
    chk({tag, " wr_addr"}, c, 32'(wr_addr), 32'd0);
    chk({tag, " wr_data"}, c, 32'(wr_data), 32'd0);
    chk({tag, " busy"},    c, 32'(busy),    32'd0);
    chk({tag, " done"},    c, 32'(done),    32'd0);
    chk({tag, " bcd_err"}, c, 32'(bcd_err), 32'd0);
  endtask

  // Full scan: start in cycle 0 (or the current cycle for back-to-back), checks through cycle 93.
  task automatic run_scan(input vec_t v);
    logic [6:0] line5 [6];
    logic [6:0] exp_ch;
    int writes;
    int k, p;
    bit we;
    line5[0] = v.d3; line5[1] = 7'h2E; line5[2] = v.d2;
    line5[3] = v.d1; line5[4] = v.d0;  line5[5] = 7'h56;
    writes = 0;
    bcd5 = v.bcd5;
    if (!v.b2b) @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 93; c++) begin
      @(negedge clk);
      start = (c == v.restart);
      k  = (c - 3) / 7;
      p  = (c - 3) % 7;
      we = (c >= 3) && (c <= 92) && (p < 6);
      chk("wr_en", c, 32'(wr_en), 32'(we));
      chk("busy",  c, 32'(busy),  32'((c >= 1) && (c <= 92)));
      chk("done",  c, 32'(done),  32'(c == 93));
      if (wr_en) writes++;
      if (we) begin
        exp_ch = (k == 5) ? line5[p] : base_line[p];
        chk("wr_addr", c, 32'(wr_addr), 32'(k * 8 + p));
        chk("wr_data", c, 32'(wr_data), 32'(exp_ch));
      end
      if ((c - 1) % 7 == 0 && c <= 85) chk("ch_addr", c, 32'(ch_addr), 32'((c - 1) / 7));
      if (c == 1) chk("bcd_err_clear", c, 32'(bcd_err), 32'd0);
    end
    chk("write_count", 93, 32'(writes), 32'd78);
    chk("bcd_err_end", 93, 32'(bcd_err), 32'(v.err));
  endtask

  initial begin
    base_line[0] = 7'h31; base_line[1] = 7'h2E; base_line[2] = 7'h32;
    base_line[3] = 7'h33; base_line[4] = 7'h34; base_line[5] = 7'h56;

    vecs[0] = '{bcd5: 16'h1234, d3: 7'h31, d2: 7'h32, d1: 7'h33, d0: 7'h34, err: 1'b0, restart: -1, b2b: 1'b0};
    vecs[1] = '{bcd5: 16'h9A05, d3: 7'h39, d2: 7'h7F, d1: 7'h30, d0: 7'h35, err: 1'b1, restart: -1, b2b: 1'b0};
    vecs[2] = '{bcd5: 16'h0000, d3: 7'h30, d2: 7'h30, d1: 7'h30, d0: 7'h30, err: 1'b0, restart: 40, b2b: 1'b0};
    vecs[3] = '{bcd5: 16'h999F, d3: 7'h39, d2: 7'h39, d1: 7'h39, d0: 7'h7F, err: 1'b1, restart: -1, b2b: 1'b1};
    vecs[4] = '{bcd5: 16'hF999, d3: 7'h7F, d2: 7'h39, d1: 7'h39, d0: 7'h39, err: 1'b1, restart: 40, b2b: 1'b1};
    vecs[5] = '{bcd5: 16'h8765, d3: 7'h38, d2: 7'h37, d1: 7'h36, d0: 7'h35, err: 1'b0, restart: -1, b2b: 1'b1};

    rst = 1'b1; start = 1'b0; bcd0 = 16'h1234; bcd5 = 16'h1234;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_idle_outputs("reset", 0);

    // Reset mid-scan with a bad digit on channel 0 so bcd_err is already set.
    bcd0 = 16'hA234;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      rst = (c == 20);
      if (c == 19) chk("pre_rst bcd_err", c, 32'(bcd_err), 32'd1);
      if (c == 21) chk_idle_outputs("mid_rst", c);
      if (c > 21) begin
        chk("post_rst wr_en", c, 32'(wr_en), 32'd0);
        chk("post_rst done",  c, 32'(done),  32'd0);
      end
    end
    bcd0 = 16'h1234;

    // start and rst together: rst wins, block stays idle.
    @(negedge clk);
    start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("start_rst busy",  c, 32'(busy),  32'd0);
      chk("start_rst wr_en", c, 32'(wr_en), 32'd0);
      @(negedge clk);
    end

    for (int i = 0; i < 6; i++) run_scan(vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
